// File: rtl/veerwolf_uart_rx.sv
// 8N1 UART receiver for the clk_core domain: two-flop input synchroniser, mid-bit
// sampling FSM and a small show-ahead receive FIFO read with valid/ready.
module veerwolf_uart_rx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_core,
  input  logic       rst_core,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF   = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t           state;
  logic             rx_p0, rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tick, push, pop, full, push_acc;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  // Stage p0/p1: synchronise the asynchronous line; both flops idle high
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= i_uart_rx;
      rx_s  <= rx_p0;
    end
  end

  assign tick = (cnt == '0);
  assign push = (state == S_STOP) && tick && rx_s;

  // Frame FSM: counter free-runs outside IDLE, reloading after every tick
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      cnt         <= tick ? RELOAD : cnt - 1'b1;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt    <= HALF;
            state  <= S_START;
            o_busy <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            if (!rx_s) begin
              bit_idx <= '0;
              state   <= S_DATA;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (rx_s) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              o_frame_err <= 1'b1;
              state       <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_core) begin
    if (state == S_DATA && tick) shreg <= {rx_s, shreg[7:1]};
  end

  // Receive FIFO: a pop in the same cycle frees the slot a full-FIFO push needs
  assign full     = (count == FULL_CNT);
  assign o_valid  = (count != '0);
  assign pop      = o_valid && i_ready;
  assign push_acc = push && (!full || pop);

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= push && full && !pop;
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_core) begin
    if (push_acc) mem[wr_ptr] <= shreg;
  end

  assign o_data = o_valid ? mem[rd_ptr] : 8'h00;

endmodule
